// File: rtl/ex_mem_flag_stage_pkg.sv
// Shared constants for the EX/MEM flag stage: opcodes, branch conditions, default widths.
package ex_mem_flag_stage_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int RADDR_W_DEF = 4;
    localparam int OP_W_DEF    = 4;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LHB    = 4'b1010;
    localparam logic [3:0] OP_LLB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

endpackage

// File: rtl/ex_mem_flag_stage_flag_unit.sv
// Architectural N/Z/V flag register with per-opcode update and branch-condition evaluation.
module ex_mem_flag_stage_flag_unit
    import ex_mem_flag_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] result,
    input  logic              ovfl,
    input  logic [2:0]        br_cond,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v,
    output logic              br_taken
);

    logic n_q, n_d;
    logic z_q, z_d;
    logic v_q, v_d;

    always_comb begin
        n_d = n_q;
        z_d = z_q;
        v_d = v_q;
        if (commit) begin
            case (opcode)
                OP_ADD, OP_SUB: begin
                    z_d = (result == '0);
                    n_d = result[DATA_W-1];
                    v_d = ovfl;
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    z_d = (result == '0);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            n_q <= n_d;
            z_q <= z_d;
            v_q <= v_d;
        end
    end

    // Registered flags only; a writer in flight is covered by the hazard unit stalling.
    always_comb begin
        br_taken = 1'b0;
        case (br_cond)
            CC_NE:     br_taken = ~z_q;
            CC_EQ:     br_taken = z_q;
            CC_GT:     br_taken = ~z_q & ~n_q;
            CC_LT:     br_taken = n_q;
            CC_GTE:    br_taken = z_q | (~z_q & ~n_q);
            CC_LTE:    br_taken = n_q | z_q;
            CC_OVFL:   br_taken = v_q;
            CC_UNCOND: br_taken = 1'b1;
            default:   br_taken = 1'b0;
        endcase
    end

    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_v = v_q;

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with stall/flush, plus the architectural flag unit.
module ex_mem_flag_stage
    import ex_mem_flag_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int OP_W    = OP_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic [OP_W-1:0]    ex_opcode,
    input  logic [DATA_W-1:0]  ex_result,
    input  logic               ex_ovfl,
    input  logic [DATA_W-1:0]  ex_store_data,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_reg_we,
    input  logic               ex_mem_rd,
    input  logic               ex_mem_wr,
    input  logic               ex_halt,
    input  logic               stall,
    input  logic               flush,
    input  logic [2:0]         br_cond,
    output logic               mem_valid,
    output logic [DATA_W-1:0]  mem_result,
    output logic [DATA_W-1:0]  mem_store_data,
    output logic [RADDR_W-1:0] mem_rd,
    output logic               mem_reg_we,
    output logic               mem_mem_rd,
    output logic               mem_mem_wr,
    output logic               mem_halt,
    output logic               flag_n,
    output logic               flag_z,
    output logic               flag_v,
    output logic               br_taken
);

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [DATA_W-1:0]  store_data_q, store_data_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic               reg_we_q, reg_we_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic               halt_q, halt_d;
    logic               commit;

    // Flush kills only the control bits; data fields keep their last value.
    always_comb begin
        valid_d      = valid_q;
        result_d     = result_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        reg_we_d     = reg_we_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        halt_d       = halt_q;
        if (flush) begin
            valid_d  = 1'b0;
            reg_we_d = 1'b0;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            halt_d   = 1'b0;
        end else if (!stall) begin
            valid_d      = ex_valid;
            result_d     = ex_result;
            store_data_d = ex_store_data;
            rd_d         = ex_rd;
            reg_we_d     = ex_reg_we & ex_valid;
            mem_rd_d     = ex_mem_rd & ex_valid;
            mem_wr_d     = ex_mem_wr & ex_valid;
            halt_d       = ex_halt & ex_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            reg_we_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            result_q     <= result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            reg_we_q     <= reg_we_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            halt_q       <= halt_d;
        end
    end

    assign commit = ex_valid & ~stall & ~flush;

    ex_mem_flag_stage_flag_unit #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_flag_unit (
        .clk      (clk),
        .rst_n    (rst_n),
        .commit   (commit),
        .opcode   (ex_opcode),
        .result   (ex_result),
        .ovfl     (ex_ovfl),
        .br_cond  (br_cond),
        .flag_n   (flag_n),
        .flag_z   (flag_z),
        .flag_v   (flag_v),
        .br_taken (br_taken)
    );

    assign mem_valid      = valid_q;
    assign mem_result     = result_q;
    assign mem_store_data = store_data_q;
    assign mem_rd         = rd_q;
    assign mem_reg_we     = reg_we_q;
    assign mem_mem_rd     = mem_rd_q;
    assign mem_mem_wr     = mem_wr_q;
    assign mem_halt       = halt_q;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed-vector bench for ex_mem_flag_stage with hand-computed expectations.
module tb_ex_mem_flag_stage;
    import ex_mem_flag_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic [15:0] ex_store_data;
    logic [3:0]  ex_rd;
    logic        ex_reg_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_halt;
    logic        stall;
    logic        flush;
    logic [2:0]  br_cond;
    logic        mem_valid;
    logic [15:0] mem_result;
    logic [15:0] mem_store_data;
    logic [3:0]  mem_rd;
    logic        mem_reg_we;
    logic        mem_mem_rd;
    logic        mem_mem_wr;
    logic        mem_halt;
    logic        flag_n;
    logic        flag_z;
    logic        flag_v;
    logic        br_taken;

    int n_vec;
    int n_err;

    ex_mem_flag_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_result      (ex_result),
        .ex_ovfl        (ex_ovfl),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_reg_we      (ex_reg_we),
        .ex_mem_rd      (ex_mem_rd),
        .ex_mem_wr      (ex_mem_wr),
        .ex_halt        (ex_halt),
        .stall          (stall),
        .flush          (flush),
        .br_cond        (br_cond),
        .mem_valid      (mem_valid),
        .mem_result     (mem_result),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_reg_we     (mem_reg_we),
        .mem_mem_rd     (mem_mem_rd),
        .mem_mem_wr     (mem_mem_wr),
        .mem_halt       (mem_halt),
        .flag_n         (flag_n),
        .flag_z         (flag_z),
        .flag_v         (flag_v),
        .br_taken       (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic n, input logic z, input logic v);
        chk({tag, ".nzv"}, {29'd0, flag_n, flag_z, flag_v}, {29'd0, n, z, v});
    endtask

    // Drive one ALU op with all side controls cleared.
    task automatic alu_op(input logic [3:0] op, input logic [15:0] res, input logic ov);
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_result     = res;
        ex_ovfl       = ov;
        ex_store_data = 16'h0000;
        ex_rd         = 4'h3;
        ex_reg_we     = 1'b1;
        ex_mem_rd     = 1'b0;
        ex_mem_wr     = 1'b0;
        ex_halt       = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_a;
    logic [7:0] sweep_b;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        sweep_a = 8'b1010_1001;  // br_cond 0..7 at bit 7..0 for Z=0,N=0,V=0
        sweep_b = 8'b1001_0111;  // same for N=1,Z=0,V=1
        br_cond = 3'b000;
        rst_n   = 1'b0;
        alu_op(OP_ADD, 16'h0000, 1'b0);
        step();

        // Load non-zero state so the reset check below is meaningful.
        rst_n = 1'b1;
        alu_op(OP_SUB, 16'h8000, 1'b1);
        ex_halt   = 1'b1;
        ex_mem_rd = 1'b1;
        step();
        chk_flags("pre_reset", 1'b1, 1'b0, 1'b1);

        rst_n = 1'b0;
        alu_op(OP_ADD, 16'h0000, 1'b0);
        stall = 1'b1;
        step();
        chk("rst.valid", {31'd0, mem_valid}, 32'd0);
        chk("rst.result", {16'd0, mem_result}, 32'd0);
        chk("rst.ctrl", {28'd0, mem_reg_we, mem_mem_rd, mem_mem_wr, mem_halt}, 32'd0);
        chk("rst.rd", {28'd0, mem_rd}, 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        alu_op(OP_ADD, 16'h0000, 1'b0);
        step();
        chk_flags("add0", 1'b0, 1'b1, 1'b0);
        chk("add0.valid", {31'd0, mem_valid}, 32'd1);
        chk("add0.reg_we", {31'd0, mem_reg_we}, 32'd1);
        chk("add0.rd", {28'd0, mem_rd}, 32'd3);

        alu_op(OP_SUB, 16'h8000, 1'b1);
        step();
        chk_flags("sub8000", 1'b1, 1'b0, 1'b1);
        chk("sub8000.result", {16'd0, mem_result}, 32'h8000);

        alu_op(OP_XOR, 16'h0000, 1'b0);
        step();
        chk_flags("xor0", 1'b1, 1'b1, 1'b1);

        alu_op(OP_PADDSB, 16'h7F80, 1'b0);
        step();
        chk_flags("paddsb", 1'b1, 1'b1, 1'b1);
        chk("paddsb.result", {16'd0, mem_result}, 32'h7F80);

        alu_op(OP_RED, 16'h0001, 1'b0);
        step();
        chk_flags("red", 1'b1, 1'b1, 1'b1);

        alu_op(OP_ADD, 16'h0005, 1'b0);
        stall = 1'b1;
        step();
        chk("stall.result", {16'd0, mem_result}, 32'h0001);
        chk_flags("stall", 1'b1, 1'b1, 1'b1);

        stall = 1'b0;
        step();
        chk("unstall.result", {16'd0, mem_result}, 32'h0005);
        chk_flags("unstall", 1'b0, 1'b0, 1'b0);

        // Flush and stall together on a store: bubble, data holds.
        alu_op(OP_SW, 16'h1234, 1'b0);
        ex_store_data = 16'hBEEF;
        ex_reg_we     = 1'b0;
        ex_mem_wr     = 1'b1;
        stall         = 1'b1;
        flush         = 1'b1;
        step();
        chk("flush.valid", {31'd0, mem_valid}, 32'd0);
        chk("flush.mem_wr", {31'd0, mem_mem_wr}, 32'd0);
        chk("flush.reg_we", {31'd0, mem_reg_we}, 32'd0);
        chk("flush.result", {16'd0, mem_result}, 32'h0005);
        chk_flags("flush_sw", 1'b0, 1'b0, 1'b0);

        // A flushed flag writer must not touch flags.
        alu_op(OP_ADD, 16'h0000, 1'b1);
        flush = 1'b1;
        step();
        chk_flags("flush_add", 1'b0, 1'b0, 1'b0);

        alu_op(OP_SW, 16'h1234, 1'b0);
        ex_store_data = 16'hBEEF;
        ex_reg_we     = 1'b0;
        ex_mem_wr     = 1'b1;
        step();
        chk("sw.ctrl", {28'd0, mem_reg_we, mem_mem_rd, mem_mem_wr, mem_halt}, 32'b0010);
        chk("sw.store", {16'd0, mem_store_data}, 32'hBEEF);
        chk("sw.result", {16'd0, mem_result}, 32'h1234);
        chk_flags("sw", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            br_cond = i[2:0];
            #1;
            chk($sformatf("br_a.cc%0d", i), {31'd0, br_taken}, {31'd0, sweep_a[7-i]});
        end

        alu_op(OP_SUB, 16'h8001, 1'b1);
        step();
        chk_flags("sub8001", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            br_cond = i[2:0];
            #1;
            chk($sformatf("br_b.cc%0d", i), {31'd0, br_taken}, {31'd0, sweep_b[7-i]});
        end

        // Flags written this edge must not be visible before the edge.
        br_cond = CC_EQ;
        alu_op(OP_ADD, 16'h0000, 1'b0);
        #1;
        chk("no_bypass", {31'd0, br_taken}, 32'd0);
        step();
        chk("eq_after", {31'd0, br_taken}, 32'd1);

        alu_op(OP_SUB, 16'h0009, 1'b0);
        ex_valid = 1'b0;
        step();
        chk("inv.reg_we", {31'd0, mem_reg_we}, 32'd0);
        chk("inv.valid", {31'd0, mem_valid}, 32'd0);
        chk("inv.result", {16'd0, mem_result}, 32'h0009);
        chk_flags("inv", 1'b0, 1'b1, 1'b0);

        alu_op(OP_LW, 16'h0040, 1'b0);
        ex_mem_rd = 1'b1;
        ex_rd     = 4'hA;
        step();
        chk("lw.ctrl", {28'd0, mem_reg_we, mem_mem_rd, mem_mem_wr, mem_halt}, 32'b1100);
        chk("lw.rd", {28'd0, mem_rd}, 32'hA);

        alu_op(OP_HLT, 16'h0000, 1'b0);
        ex_reg_we = 1'b0;
        ex_halt   = 1'b1;
        step();
        chk("hlt.halt", {31'd0, mem_halt}, 32'd1);
        chk_flags("hlt", 1'b0, 1'b1, 1'b0);

        alu_op(OP_SLL, 16'h0100, 1'b1);
        step();
        chk("post_hlt.halt", {31'd0, mem_halt}, 32'd0);
        chk_flags("sll", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
